mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator between the CPU datapath and the word-wide synchronous RAM (17-bit word address, one-cycle registered read, no byte enables). It accepts one RISC-V load or store per request, drives `ramR`/`ramW`/`ramAddr`/`ramDataW`, and captures `ramDataR`. It performs read-modify-write for SB/SH and byte/halfword extraction with sign or zero extension for loads. It returns a one-cycle `done` pulse with the result or a fault.

## Interface
- `n`, 32: data width (CPU and RAM word).
- `AW`, 17: RAM word-address width.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in n: byte address (rs1+imm).
- `wdata` in n: store data (rs2); low byte/half used for SB/SH.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; illegal funct3 or misaligned access.
- `rdata` out n: extended load result, registered, held until next load completes.
- `ramR`, `ramW` out 1: RAM read/write enables.
- `ramAddr` out AW: `addr[AW+1:2]`.
- `ramDataW` out n: word written.
- `ramDataR` in n: RAM read data, valid the cycle after `ramR`.

## Operation
- Little-endian: byte k = bits [8k+7:8k]; offset = `addr[1:0]`; `addr[n-1:AW+2]` ignored (aliases).
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE + `req`: illegal funct3 (011/110/111; 100/101 with `we`) or fault → DONE with fault=1, no RAM access; LW/LB/LH/LBU/LHU/SB/SH → RD; SW → WR.
- RD: `ramR`=1, `ramAddr` latched. → CAP.
- CAP: load → register extended `rdata`, → DONE; SB/SH → merge `wdata` byte/half into `ramDataR` at offset into write register, → WR.
- WR: `ramW`=1, `ramDataW` = merged word (SW: `wdata`). → DONE.
- DONE: `done`=1, `fault` as latched. → IDLE.
- Request fields latched at acceptance; `req` while busy ignored (no queuing).
- LB/LH sign-extend, LBU/LHU zero-extend; LW passes through.
- Reset values: state IDLE, `busy`/`done`/`fault`/`ramR`/`ramW` 0, `rdata`/`ramAddr`/`ramDataW` 0.

## Timing
- Request accepted at edge 0 (cycle 0 = `req` high in IDLE).
- LW/LB/LH: `ramR` cycle 1, `done`+`rdata` cycle 3.
- SW: `ramW` cycle 1, `done` cycle 2.
- SB/SH: `ramR` cycle 1, `ramW` cycle 3, `done` cycle 4.
- Fault: `done`+`fault` cycle 1.
- Back-to-back: next `req` accepted in the cycle after `done` (IDLE), earliest.
- `ramR`/`ramW` are Moore outputs of the state; never both high.
- Reset mid-operation: next state IDLE, no `done`. A WR cycle coinciding with the reset edge still writes (RAM is not reset); reset in RD/CAP leaves memory unchanged.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`!=0 → fault, no RAM access.
- Undefined: no misalignment fault; halfword offset forced to `{addr[1],0}`, word offset to 0, access proceeds normally. Illegal funct3 faults in both builds.

## Structure
- `mem_pkg`: state enum, funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), `RAM_AW`=17.
- One sub-module `mem_align`: combinational byte/half extraction + extension (load) and byte/half merge (store), shared by CAP.

## Test plan
- Reset, SW addr 0x10 wdata 0xDEADBEEF → cycle 1 `ramW`=1, `ramAddr`=4, `ramDataW`=0xDEADBEEF; `done` cycle 2, `fault`=0.
- LB addr 0x13 → `ramR` cycle 1 `ramAddr`=4; cycle 3 `rdata`=0xFFFFFFDE; LBU same addr → 0x000000DE.
- SB addr 0x11 wdata 0x55 → `ramW` cycle 3 with `ramDataW`=0xDEAD55EF, `done` cycle 4; subsequent LW 0x10 → 0xDEAD55EF.
- LH addr 0x12 → 0xFFFFDEAD; LHU → 0x0000DEAD; SH addr 0x10 wdata 0x1234 → word 0xDEAD1234.
- LW addr 0x11: with macro → `done`+`fault` cycle 1, no `ramR`; without → reads word 4, `fault`=0. funct3 011 → fault in both.
- Reset asserted in CAP of SB addr 0x10 → no `ramW`, `busy`=0 next cycle, no `done`, LW 0x10 returns unchanged word.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store initiator: FSM state encoding,
// RISC-V funct3 width/sign codes, RAM word-address width, and the
// funct3 legality check used at request acceptance.
package mem_pkg;

    localparam int RAM_AW = 17;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Unsigned variants exist only for loads; 011/110/111 are never legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and RAM port bundle for mem_access_ctrl.
// master: the CPU datapath plus RAM model side; slave: the controller.
interface mem_access_ctrl_if #(
    parameter int n  = 32,
    parameter int AW = 17
);
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [n-1:0]  addr;
    logic [n-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          fault;
    logic [n-1:0]  rdata;
    logic          ramR;
    logic          ramW;
    logic [AW-1:0] ramAddr;
    logic [n-1:0]  ramDataW;
    logic [n-1:0]  ramDataR;

    modport master (
        output req, we, funct3, addr, wdata, ramDataR,
        input  busy, done, fault, rdata, ramR, ramW, ramAddr, ramDataW
    );

    modport slave (
        input  req, we, funct3, addr, wdata, ramDataR,
        output busy, done, fault, rdata, ramR, ramW, ramAddr, ramDataW
    );
endinterface

// File: rtl/mem_access_ctrl_align.sv
// mem_align: combinational little-endian lane handling for the CAP state.
// Load path extracts the byte/half at the offset and sign- or zero-extends;
// store path merges the low byte/half of the store data into the read word.
module mem_align
    import mem_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [2:0]   i_f3,
    input  logic [1:0]   i_off,
    input  logic [n-1:0] i_rword,
    input  logic [n-1:0] i_wdata,
    output logic [n-1:0] o_ldata,
    output logic [n-1:0] o_mword
);

    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes of the read word.
    always_comb begin
        w_bsh  = {i_off, 3'b000};
        w_hsh  = {i_off[1], 4'b0000};
        w_byte = i_rword[w_bsh +: 8];
        w_half = i_rword[w_hsh +: 16];
    end

    // Load result: extend the selected lane; words pass straight through.
    always_comb begin
        case (i_f3)
            F3_B:    o_ldata = {{(n-8){w_byte[7]}}, w_byte};
            F3_H:    o_ldata = {{(n-16){w_half[15]}}, w_half};
            F3_BU:   o_ldata = {{(n-8){1'b0}}, w_byte};
            F3_HU:   o_ldata = {{(n-16){1'b0}}, w_half};
            default: o_ldata = i_rword;
        endcase
    end

    // Store word: overwrite only the addressed lane of the current contents.
    always_comb begin
        o_mword = i_rword;
        case (i_f3)
            F3_B:    o_mword[w_bsh +: 8]  = i_wdata[7:0];
            F3_H:    o_mword[w_hsh +: 16] = i_wdata[15:0];
            default: o_mword = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: RISC-V load/store initiator for a word-wide synchronous
// RAM with a one-cycle registered read and no byte enables. Sub-word stores
// are done as read-modify-write. Optional macro MEM_ALIGN_CHECK_EN turns
// misaligned halfword/word accesses into faults; without it the low address
// bits are forced to the natural alignment and the access proceeds.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int n  = 32,
    parameter int AW = RAM_AW
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);

    state_t        r_state;
    state_t        w_next;

    logic          r_we;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [n-1:0]  r_wdata;
    logic          r_fault;
    logic [AW-1:0] r_addr;
    logic [n-1:0]  r_wword;
    logic [n-1:0]  r_rdata;

    logic          w_accept;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_fault_req;
    logic          w_is_sw;
    logic [1:0]    w_off;
    logic [n-1:0]  w_ldata;
    logic [n-1:0]  w_mword;

    // Upper byte-address bits alias onto the same RAM word.
    logic          w_unused_addr;
    assign w_unused_addr = ^bus.addr[n-1:AW+2];

    // Classify the incoming request: legality, alignment and effective offset.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && bus.req;
        w_illegal  = !f3_legal(bus.funct3, bus.we);
        w_misalign = 1'b0;
        w_off      = bus.addr[1:0];
        w_is_sw    = bus.we && (bus.funct3 == F3_W);
        case (bus.funct3)
            F3_H, F3_HU: begin
`ifdef MEM_ALIGN_CHECK_EN
                w_misalign = bus.addr[0];
`else
                w_off = {bus.addr[1], 1'b0};
`endif
            end
            F3_W: begin
`ifdef MEM_ALIGN_CHECK_EN
                w_misalign = |bus.addr[1:0];
`else
                w_off = 2'b00;
`endif
            end
            default: ;
        endcase
        w_fault_req = w_illegal || w_misalign;
    end

    // State register; reset abandons any operation without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore outputs of the state.
    always_comb begin
        w_next   = r_state;
        bus.ramR = 1'b0;
        bus.ramW = 1'b0;
        bus.busy = 1'b1;
        bus.done = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.req) begin
                    if (w_fault_req) begin
                        w_next = S_DONE;
                    end else if (w_is_sw) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                bus.ramR = 1'b1;
                w_next   = S_CAP;
            end
            S_CAP: begin
                w_next = r_we ? S_WR : S_DONE;
            end
            S_WR: begin
                bus.ramW = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch request fields at acceptance and capture RAM data in CAP.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_f3    <= F3_B;
            r_off   <= 2'b00;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_addr  <= '0;
            r_wword <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we;
                r_f3    <= bus.funct3;
                r_off   <= w_off;
                r_wdata <= bus.wdata;
                r_fault <= w_fault_req;
                if (!w_fault_req) begin
                    r_addr <= bus.addr[AW+1:2];
                    if (w_is_sw) begin
                        r_wword <= bus.wdata;
                    end
                end
            end
            if (r_state == S_CAP) begin
                if (r_we) begin
                    r_wword <= w_mword;
                end else begin
                    r_rdata <= w_ldata;
                end
            end
        end
    end

    mem_align #(
        .n (n)
    ) u_align (
        .i_f3    (r_f3),
        .i_off   (r_off),
        .i_rword (bus.ramDataR),
        .i_wdata (r_wdata),
        .o_ldata (w_ldata),
        .o_mword (w_mword)
    );

    // Registered results onto the bus; fault is only meaningful with done.
    always_comb begin
        bus.fault    = r_fault && (r_state == S_DONE);
        bus.rdata    = r_rdata;
        bus.ramAddr  = r_addr;
        bus.ramDataW = r_wword;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl. The bench plays the CPU
// and a small synchronous RAM (one-cycle registered read). Cycle k of a
// request is the k-th clock period after the one in which req was presented.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    mem_access_ctrl_if #(.n(32), .AW(17)) bus ();

    mem_access_ctrl #(.n(32), .AW(17)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on ramW, registered read on ramR.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.ramW) mem[bus.ramAddr[7:0]] <= bus.ramDataW;
        if (bus.ramR) bus.ramDataR <= mem[bus.ramAddr[7:0]];
    end

    // Per-cycle trace of one request, cycles 1..8.
    logic        tr_r  [1:8];
    logic        tr_w  [1:8];
    logic        tr_d  [1:8];
    logic        tr_f  [1:8];
    logic        tr_b  [1:8];
    logic [16:0] tr_a  [1:8];
    logic [31:0] tr_dw [1:8];
    logic [31:0] tr_rd [1:8];

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit hold);
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tr_r[k] = bus.ramR;  tr_w[k] = bus.ramW;  tr_d[k] = bus.done;
            tr_f[k] = bus.fault; tr_b[k] = bus.busy;  tr_a[k] = bus.ramAddr;
            tr_dw[k] = bus.ramDataW; tr_rd[k] = bus.rdata;
            if (!hold) bus.req = 1'b0;
        end
        bus.req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0 || bus.fault !== 1'b0) $display("FAIL reset_done_fault: got %b%b want 00", bus.done, bus.fault); else pass_cnt++;
        total_cnt++; if (bus.ramR !== 1'b0 || bus.ramW !== 1'b0) $display("FAIL reset_ram_en: got %b%b want 00", bus.ramR, bus.ramW); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 32'h0 || bus.ramDataW !== 32'h0 || bus.ramAddr !== 17'h0) $display("FAIL reset_data: got %h %h %h want 0", bus.rdata, bus.ramDataW, bus.ramAddr); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_sw;
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        total_cnt++; if (tr_w[1] !== 1'b1 || tr_r[1] !== 1'b0) $display("FAIL sw_ramW_c1: got W%b R%b want W1 R0", tr_w[1], tr_r[1]); else pass_cnt++;
        total_cnt++; if (tr_a[1] !== 17'd4) $display("FAIL sw_ramAddr: got %h want 4", tr_a[1]); else pass_cnt++;
        total_cnt++; if (tr_dw[1] !== 32'hDEAD_BEEF) $display("FAIL sw_ramDataW: got %h want deadbeef", tr_dw[1]); else pass_cnt++;
        total_cnt++; if (tr_d[1] !== 1'b0 || tr_d[2] !== 1'b1 || tr_f[2] !== 1'b0) $display("FAIL sw_done_c2: got d1=%b d2=%b f=%b want 0 1 0", tr_d[1], tr_d[2], tr_f[2]); else pass_cnt++;
        total_cnt++; if (tr_b[3] !== 1'b0 || tr_d[3] !== 1'b0) $display("FAIL sw_idle_c3: got busy=%b done=%b want 0 0", tr_b[3], tr_d[3]); else pass_cnt++;
    endtask

    task automatic test_byte_load;
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0, 1'b0);
        total_cnt++; if (tr_r[1] !== 1'b1 || tr_a[1] !== 17'd4) $display("FAIL lb_ramR_c1: got R%b addr %h want R1 addr 4", tr_r[1], tr_a[1]); else pass_cnt++;
        total_cnt++; if (tr_d[2] !== 1'b0 || tr_d[3] !== 1'b1) $display("FAIL lb_done_c3: got d2=%b d3=%b want 0 1", tr_d[2], tr_d[3]); else pass_cnt++;
        total_cnt++; if (tr_rd[3] !== 32'hFFFF_FFDE) $display("FAIL lb_rdata: got %h want ffffffde", tr_rd[3]); else pass_cnt++;
        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'h0000_00DE) $display("FAIL lbu_rdata: got %h want 000000de", tr_rd[3]); else pass_cnt++;
    endtask

    task automatic test_byte_store;
        issue(1'b1, 3'b000, 32'h0000_0011, 32'h7777_7755, 1'b0);
        total_cnt++; if (tr_r[1] !== 1'b1 || tr_w[2] !== 1'b0 || tr_w[3] !== 1'b1) $display("FAIL sb_seq: got R1=%b W2=%b W3=%b want 1 0 1", tr_r[1], tr_w[2], tr_w[3]); else pass_cnt++;
        total_cnt++; if (tr_dw[3] !== 32'hDEAD_55EF) $display("FAIL sb_ramDataW: got %h want dead55ef", tr_dw[3]); else pass_cnt++;
        total_cnt++; if (tr_d[3] !== 1'b0 || tr_d[4] !== 1'b1 || tr_f[4] !== 1'b0) $display("FAIL sb_done_c4: got d3=%b d4=%b f=%b want 0 1 0", tr_d[3], tr_d[4], tr_f[4]); else pass_cnt++;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'hDEAD_55EF) $display("FAIL sb_readback: got %h want dead55ef", tr_rd[3]); else pass_cnt++;
    endtask

    task automatic test_half;
        issue(1'b0, 3'b001, 32'h0000_0012, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'hFFFF_DEAD) $display("FAIL lh_rdata: got %h want ffffdead", tr_rd[3]); else pass_cnt++;
        issue(1'b0, 3'b101, 32'h0000_0012, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'h0000_DEAD) $display("FAIL lhu_rdata: got %h want 0000dead", tr_rd[3]); else pass_cnt++;
        issue(1'b1, 3'b001, 32'h0000_0010, 32'hABCD_1234, 1'b0);
        total_cnt++; if (tr_w[3] !== 1'b1 || tr_dw[3] !== 32'hDEAD_1234) $display("FAIL sh_ramDataW: got W%b %h want W1 dead1234", tr_w[3], tr_dw[3]); else pass_cnt++;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'hDEAD_1234) $display("FAIL sh_readback: got %h want dead1234", tr_rd[3]); else pass_cnt++;
    endtask

    task automatic test_misalign;
        issue(1'b0, 3'b010, 32'h0000_0011, 32'h0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        total_cnt++; if (tr_d[1] !== 1'b1 || tr_f[1] !== 1'b1) $display("FAIL lw_mis_fault: got d=%b f=%b want 1 1", tr_d[1], tr_f[1]); else pass_cnt++;
        total_cnt++; if (tr_r[1] !== 1'b0 || tr_r[2] !== 1'b0) $display("FAIL lw_mis_noread: got %b%b want 00", tr_r[1], tr_r[2]); else pass_cnt++;
`else
        total_cnt++; if (tr_r[1] !== 1'b1 || tr_a[1] !== 17'd4) $display("FAIL lw_mis_read: got R%b addr %h want R1 addr 4", tr_r[1], tr_a[1]); else pass_cnt++;
        total_cnt++; if (tr_d[3] !== 1'b1 || tr_f[3] !== 1'b0 || tr_rd[3] !== 32'hDEAD_1234) $display("FAIL lw_mis_result: got d=%b f=%b %h want 1 0 dead1234", tr_d[3], tr_f[3], tr_rd[3]); else pass_cnt++;
`endif
    endtask

    task automatic test_illegal;
        issue(1'b0, 3'b011, 32'h0000_0010, 32'h0, 1'b0);
        total_cnt++; if (tr_d[1] !== 1'b1 || tr_f[1] !== 1'b1) $display("FAIL f3_011_fault: got d=%b f=%b want 1 1", tr_d[1], tr_f[1]); else pass_cnt++;
        total_cnt++; if (tr_r[1] !== 1'b0 || tr_w[1] !== 1'b0 || tr_b[2] !== 1'b0) $display("FAIL f3_011_noaccess: got R%b W%b busy2=%b want 0 0 0", tr_r[1], tr_w[1], tr_b[2]); else pass_cnt++;
        total_cnt++; if (tr_rd[1] !== 32'hDEAD_1234) $display("FAIL f3_011_rdata_held: got %h want dead1234", tr_rd[1]); else pass_cnt++;
        issue(1'b1, 3'b100, 32'h0000_0010, 32'h0, 1'b0);
        total_cnt++; if (tr_d[1] !== 1'b1 || tr_f[1] !== 1'b1 || tr_w[1] !== 1'b0) $display("FAIL sbu_fault: got d=%b f=%b W=%b want 1 1 0", tr_d[1], tr_f[1], tr_w[1]); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1);
        total_cnt++; if (tr_r[1] !== 1'b1 || tr_r[2] !== 1'b0 || tr_r[3] !== 1'b0 || tr_r[4] !== 1'b0 || tr_r[5] !== 1'b1) $display("FAIL b2b_ramR: got %b%b%b%b%b want 10001", tr_r[1], tr_r[2], tr_r[3], tr_r[4], tr_r[5]); else pass_cnt++;
        total_cnt++; if (tr_d[3] !== 1'b1 || tr_d[4] !== 1'b0 || tr_d[7] !== 1'b1) $display("FAIL b2b_done: got d3=%b d4=%b d7=%b want 1 0 1", tr_d[3], tr_d[4], tr_d[7]); else pass_cnt++;
        total_cnt++; if (tr_b[4] !== 1'b0 || tr_b[5] !== 1'b1) $display("FAIL b2b_busy: got b4=%b b5=%b want 0 1", tr_b[4], tr_b[5]); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic w_seen;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h10; bus.wdata = 32'h99;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ramW !== 1'b0) $display("FAIL rst_mid_state: got busy=%b done=%b W=%b want 0 0 0", bus.busy, bus.done, bus.ramW); else pass_cnt++;
        rst = 1'b0;
        w_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.ramW) w_seen = 1'b1;
        end
        total_cnt++; if (w_seen !== 1'b0) $display("FAIL rst_mid_quiet: got %b want 0", w_seen); else pass_cnt++;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
        total_cnt++; if (tr_rd[3] !== 32'hDEAD_1234) $display("FAIL rst_mid_mem: got %h want dead1234", tr_rd[3]); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset;
        test_sw;
        test_byte_load;
        test_byte_store;
        test_half;
        test_misalign;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
